// File: rtl/tx_buffer_frag.sv
// Circular location buffer feeding the TL TX fragmentation path.
// Accepts bursts of up to MAX_WR locations and returns one or two per read.
module tx_buffer_frag #(
    parameter int unsigned LOC_W  = 128,
    parameter int unsigned MAX_WR = 9,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1),
    localparam int unsigned NLW_W = $clog2(MAX_WR + 1)
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    wr_en,
    input  logic [MAX_WR*LOC_W-1:0] data_in,
    input  logic [NLW_W-1:0]        no_loc_wr,
    input  logic                    rd_en,
    input  logic                    rd_mode,
    output logic [2*LOC_W-1:0]      data_out,
    output logic                    data_out_valid,
    output logic [1:0]              no_loc_rd,
    output logic                    Buffer_Ready,
    output logic                    start_fragment,
    output logic                    empty,
    output logic [CNT_W-1:0]        count
);

    logic [LOC_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [CNT_W-1:0] free_c;
    logic [CNT_W-1:0] wr_n_c;
    logic [CNT_W-1:0] rd_n_c;
    logic             wr_ok_c;

    // Write acceptance uses the pre-read count, so a same-cycle read never frees space early.
    always_comb begin
        free_c  = CNT_W'(DEPTH) - count;
        wr_ok_c = wr_en && (no_loc_wr != '0) && (no_loc_wr <= NLW_W'(MAX_WR))
                  && (free_c >= CNT_W'(no_loc_wr));
        wr_n_c  = wr_ok_c ? CNT_W'(no_loc_wr) : '0;
        rd_n_c  = '0;
        if (rd_en) begin
            if (rd_mode && (count >= CNT_W'(2))) begin
                rd_n_c = CNT_W'(2);
            end else if (count != '0) begin
                rd_n_c = CNT_W'(1);
            end
        end
    end

    // Storage is not reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!arst && wr_ok_c) begin
            for (int unsigned k = 0; k < MAX_WR; k++) begin
                if (NLW_W'(k) < no_loc_wr) begin
                    mem[wr_ptr + PTR_W'(k)] <= data_in[k*LOC_W +: LOC_W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            no_loc_rd      <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_n_c);
            rd_ptr <= rd_ptr + PTR_W'(rd_n_c);
            count  <= count + wr_n_c - rd_n_c;
            if (rd_n_c != '0) begin
                data_out[LOC_W-1:0]       <= mem[rd_ptr];
                data_out[2*LOC_W-1:LOC_W] <= (rd_n_c == CNT_W'(2)) ? mem[rd_ptr + PTR_W'(1)] : '0;
                data_out_valid            <= 1'b1;
                no_loc_rd                 <= 2'(rd_n_c);
            end else begin
                data_out_valid <= 1'b0;
                no_loc_rd      <= '0;
            end
        end
    end

    assign Buffer_Ready   = (free_c >= CNT_W'(MAX_WR));
    assign start_fragment = (count != '0);
    assign empty          = (count == '0);

endmodule

// File: tb/tb_tx_buffer_frag.sv
// Self-checking bench for tx_buffer_frag: directed vector table plus
// randomized traffic checked against a queue-based reference model.
module tb_tx_buffer_frag;

    localparam int unsigned LOC_W  = 128;
    localparam int unsigned MAX_WR = 9;
    localparam int unsigned DEPTH  = 32;

    logic                    clk;
    logic                    arst;
    logic                    wr_en;
    logic [MAX_WR*LOC_W-1:0] data_in;
    logic [3:0]              no_loc_wr;
    logic                    rd_en;
    logic                    rd_mode;
    logic [2*LOC_W-1:0]      data_out;
    logic                    data_out_valid;
    logic [1:0]              no_loc_rd;
    logic                    Buffer_Ready;
    logic                    start_fragment;
    logic                    empty;
    logic [5:0]              count;

    tx_buffer_frag dut (
        .clk            (clk),
        .arst           (arst),
        .wr_en          (wr_en),
        .data_in        (data_in),
        .no_loc_wr      (no_loc_wr),
        .rd_en          (rd_en),
        .rd_mode        (rd_mode),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .no_loc_rd      (no_loc_rd),
        .Buffer_Ready   (Buffer_Ready),
        .start_fragment (start_fragment),
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic         we;
        logic [3:0]   nw;
        logic         re;
        logic         rm;
        logic         exp_valid;
        logic [1:0]   exp_nrd;
        logic [127:0] exp_lo;
        logic [127:0] exp_hi;
        logic [5:0]   exp_cnt;
        logic         exp_rdy;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [3:0] nw, input logic re, input logic rm,
                                input logic v, input logic [1:0] nrd, input logic [127:0] lo,
                                input logic [127:0] hi, input logic [5:0] cnt, input logic rdy);
        vec_t r;
        r.we = we; r.nw = nw; r.re = re; r.rm = rm;
        r.exp_valid = v; r.exp_nrd = nrd; r.exp_lo = lo; r.exp_hi = hi;
        r.exp_cnt = cnt; r.exp_rdy = rdy;
        return r;
    endfunction

    function automatic logic [MAX_WR*LOC_W-1:0] rand_data();
        logic [MAX_WR*LOC_W-1:0] d;
        for (int i = 0; i < 36; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Reference model: the buffer is simply an ordered queue of locations.
    logic [127:0] q[$];
    logic [255:0] m_dout;
    logic         m_valid;
    logic [1:0]   m_nrd;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = q.size();
        chk({tag, " data_out"}, data_out, m_dout);
        chk({tag, " valid"}, 256'(data_out_valid), 256'(m_valid));
        chk({tag, " no_loc_rd"}, 256'(no_loc_rd), 256'(m_nrd));
        chk({tag, " count"}, 256'(count), 256'(sz));
        chk({tag, " Buffer_Ready"}, 256'(Buffer_Ready), 256'((DEPTH - sz) >= MAX_WR));
        chk({tag, " start_fragment"}, 256'(start_fragment), 256'(sz > 0));
        chk({tag, " empty"}, 256'(empty), 256'(sz == 0));
    endtask

    task automatic cycle(input string tag, input logic we, input logic [MAX_WR*LOC_W-1:0] d,
                         input logic [3:0] nw, input logic re, input logic rm);
        int pre;
        int n;
        wr_en = we; data_in = d; no_loc_wr = nw; rd_en = re; rd_mode = rm;
        @(posedge clk);
        pre = q.size();
        n = 0;
        if (re) n = (rm && pre >= 2) ? 2 : (pre >= 1 ? 1 : 0);
        if (n > 0) begin
            m_valid = 1'b1;
            m_nrd   = 2'(n);
            m_dout[127:0]   = q.pop_front();
            m_dout[255:128] = (n == 2) ? q.pop_front() : 128'h0;
        end else begin
            m_valid = 1'b0;
            m_nrd   = 2'd0;
        end
        if (we && nw >= 1 && nw <= MAX_WR && (DEPTH - pre) >= nw) begin
            for (int k = 0; k < int'(nw); k++) q.push_back(d[k*LOC_W +: LOC_W]);
        end
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick();
        arst = 1'b0;
        q.delete();
        m_dout = '0; m_valid = 1'b0; m_nrd = 2'd0;
    endtask

    localparam logic [127:0] L0 = 128'heeeeffff_aaaabbbb_ccccdddd_eeeeffff;
    localparam logic [127:0] L1 = 128'hccccdddd_eeeeffff_aaaabbbb_ccccdddd;
    localparam logic [127:0] L2 = 128'haaaabbbb_ccccdddd_eeeeffff_aaaabbbb;
    localparam logic [127:0] Z  = 128'h0;

    vec_t vecs[$];
    logic [MAX_WR*LOC_W-1:0] pat;

    initial begin
        arst = 1'b1; wr_en = 1'b0; data_in = '0; no_loc_wr = '0; rd_en = 1'b0; rd_mode = 1'b0;
        for (int i = 0; i < 12; i++) pat[i*96 +: 96] = 96'haaaabbbb_ccccdddd_eeeeffff;

        tick();
        arst = 1'b0;
        tick();
        chk("idle Buffer_Ready", 256'(Buffer_Ready), 256'(1));
        chk("idle start_fragment", 256'(start_fragment), 256'(0));
        chk("idle empty", 256'(empty), 256'(1));
        chk("idle valid", 256'(data_out_valid), 256'(0));
        chk("idle count", 256'(count), 256'(0));

        vecs.push_back(mk(1, 4, 0, 0, 0, 0, Z,  Z,  4,  1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, L0, Z,  3,  1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, L1, Z,  2,  1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, L2, Z,  1,  1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, L0, Z,  0,  1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, L0, Z,  0,  1));
        vecs.push_back(mk(1, 4, 0, 0, 0, 0, L0, Z,  4,  1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2, L0, L1, 2,  1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2, L2, L0, 0,  1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, L2, L0, 0,  1));
        vecs.push_back(mk(1, 3, 0, 0, 0, 0, L2, L0, 3,  1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 2, L0, L1, 1,  1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, L2, Z,  0,  1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, L2, Z,  0,  1));
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, L2, Z, 0,  1));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, L2, Z,  9,  1));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, L2, Z,  18, 1));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, L2, Z,  27, 0));
        vecs.push_back(mk(1, 9, 0, 0, 0, 0, L2, Z,  27, 0));
        vecs.push_back(mk(1, 5, 0, 0, 0, 0, L2, Z,  32, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, L2, Z,  32, 0));

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            wr_en = vecs[i].we; data_in = pat; no_loc_wr = vecs[i].nw;
            rd_en = vecs[i].re; rd_mode = vecs[i].rm;
            tick();
            chk({t, " valid"}, 256'(data_out_valid), 256'(vecs[i].exp_valid));
            chk({t, " no_loc_rd"}, 256'(no_loc_rd), 256'(vecs[i].exp_nrd));
            chk({t, " data_lo"}, 256'(data_out[127:0]), 256'(vecs[i].exp_lo));
            chk({t, " data_hi"}, 256'(data_out[255:128]), 256'(vecs[i].exp_hi));
            chk({t, " count"}, 256'(count), 256'(vecs[i].exp_cnt));
            chk({t, " Buffer_Ready"}, 256'(Buffer_Ready), 256'(vecs[i].exp_rdy));
            chk({t, " empty"}, 256'(empty), 256'(vecs[i].exp_cnt == 6'd0));
            chk({t, " start_fragment"}, 256'(start_fragment), 256'(vecs[i].exp_cnt != 6'd0));
        end

        // Sustained write-9/read-2 traffic forces both pointers around the ring.
        do_reset();
        check_model("post reset");
        for (int i = 0; i < 16; i++) cycle($sformatf("wrap%0d", i), 1'b1, rand_data(), 4'd9, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) cycle($sformatf("drain%0d", i), 1'b0, '0, 4'd0, 1'b1, 1'b1);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] nw;
            nw = 4'($urandom_range(0, 11));
            cycle($sformatf("rnd%0d", i), 1'($urandom), rand_data(), nw, 1'($urandom_range(0, 3) != 0),
                  1'($urandom));
        end

        // Reset in the middle of traffic, with read and write also requested.
        for (int i = 0; i < 6; i++) cycle($sformatf("pre%0d", i), 1'b1, rand_data(), 4'd7, 1'b1, 1'b0);
        arst = 1'b1; wr_en = 1'b1; no_loc_wr = 4'd9; rd_en = 1'b1; rd_mode = 1'b1;
        tick();
        chk("midrst count", 256'(count), 256'(0));
        chk("midrst valid", 256'(data_out_valid), 256'(0));
        chk("midrst no_loc_rd", 256'(no_loc_rd), 256'(0));
        chk("midrst data_out", data_out, 256'(0));
        chk("midrst empty", 256'(empty), 256'(1));
        chk("midrst Buffer_Ready", 256'(Buffer_Ready), 256'(1));
        arst = 1'b0;
        q.delete();
        m_dout = '0; m_valid = 1'b0; m_nrd = 2'd0;
        cycle("after rst wr", 1'b1, rand_data(), 4'd3, 1'b0, 1'b0);
        cycle("after rst rd", 1'b0, '0, 4'd0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
